// File: rtl/regfile_sb_pkg.sv
// Shared types and default sizing for the scoreboarded register file.
// The FSM only distinguishes the power-up zeroing sweep from normal operation.
package regfile_sb_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_ADDR_W = 4;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// A same-cycle writeback to a source hides its hazard.
module regfile_scoreboard
    import regfile_sb_pkg::*;
#(
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic              rs1_busy,
    output logic              rs2_busy
);

    localparam int NREGS = 2 ** ADDR_W;

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;

    // Clear is applied before set so a simultaneous issue to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (run) begin
            if (wr_en) begin
                pending_d[wr_addr] = 1'b0;
            end
            if (iss_en && !(R0_ZERO && (iss_rd == '0))) begin
                pending_d[iss_rd] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_comb begin
        rs1_busy = run && pending_q[rs1] && !(wr_en && (wr_addr == rs1));
        rs2_busy = run && pending_q[rs2] && !(wr_en && (wr_addr == rs2));
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with two bypassed async read ports, one write port, a zeroing
// sweep after reset, and a pending-write scoreboard for hazard detection.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W  = DEFAULT_DATA_W,
    parameter int ADDR_W  = DEFAULT_ADDR_W,
    parameter bit R0_ZERO = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              rs1_neg,
    output logic              rs1_zero,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              iss_en,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              ready
);

    localparam int NREGS = 2 ** ADDR_W;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] idx_d;
    logic              ready_q;
    logic              ready_d;

    logic [DATA_W-1:0] regs_q [NREGS];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              run;

    assign run = (state_q == RUN) && !rst;

    // The sweep and normal writeback share the single storage write port.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        ready_d   = ready_q;
        mem_we    = 1'b0;
        mem_addr  = idx_q;
        mem_wdata = '0;
        case (state_q)
            INIT: begin
                mem_we = 1'b1;
                idx_d  = idx_q + ADDR_W'(1);
                if (idx_q == ADDR_W'(NREGS - 1)) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end
            end
            RUN: begin
                if (wr_en && !(R0_ZERO && (wr_addr == '0))) begin
                    mem_we    = 1'b1;
                    mem_addr  = wr_addr;
                    mem_wdata = wr_data;
                end
            end
            default: begin
                state_d = INIT;
                ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
        end
    end

    // Contents are zeroed only by the sweep; reset merely restarts it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            regs_q[mem_addr] <= mem_wdata;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (run) begin
            if (wr_en && (wr_addr == rs1)) begin
                rs1_data = wr_data;
            end else begin
                rs1_data = regs_q[rs1];
            end
            if (wr_en && (wr_addr == rs2)) begin
                rs2_data = wr_data;
            end else begin
                rs2_data = regs_q[rs2];
            end
            if (R0_ZERO && (rs1 == '0)) begin
                rs1_data = '0;
            end
            if (R0_ZERO && (rs2 == '0)) begin
                rs2_data = '0;
            end
        end
    end

    always_comb begin
        rs1_neg  = rs1_data[DATA_W-1];
        rs1_zero = !rst && (rs1_data == '0);
        ready    = ready_q && !rst;
    end

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .R0_ZERO (R0_ZERO)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .iss_en   (iss_en),
        .iss_rd   (iss_rd),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rs1      (rs1),
        .rs2      (rs2),
        .rs1_busy (rs1_busy),
        .rs2_busy (rs2_busy)
    );

endmodule
